// File: rtl/serial_adder_subtracter_if.sv
// Handshake and operand/result bundle between the control unit and the
// digit-serial adder/subtracter. WIDTH must match the attached block.
interface serial_adder_subtracter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  // Control unit side: issues requests, observes results.
  modport master (
    output start, cmd, a, b,
    input  ready, done, result, carryout, overflow, zero
  );

  // Arithmetic block side.
  modport slave (
    input  start, cmd, a, b,
    output ready, done, result, carryout, overflow, zero
  );
endinterface

// File: rtl/serial_adder_subtracter.sv
// Digit-serial ADD/SUB/SLT unit. Consumes DIGIT bits per clock over
// WIDTH/DIGIT cycles, keeping the carry in a register between digits.
// Optional build macro: ADDSUB_ACCUM_EN -- cmd[2]=1 takes operand A from the
// result register instead of port a, allowing chained sums.
module serial_adder_subtracter #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input logic                      clk,
  input logic                      reset,
  serial_adder_subtracter_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SH = WIDTH - DIGIT;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder_subtracter: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Operand and working registers
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q;
  logic             slt_q;
  logic             nz_q, nz_d;
  logic [CW-1:0]    cnt_q;

  // Architectural outputs
  logic [WIDTH-1:0] result_q;
  logic             carryout_q, overflow_q, zero_q;

  // Command decode and operand-A source
  logic             sub_cmd, slt_cmd, accept, last;
  logic [WIDTH-1:0] a_src;

  assign sub_cmd = bus.cmd[0];
`ifdef ADDSUB_ACCUM_EN
  assign slt_cmd = (bus.cmd[1:0] == 2'b11);
  assign a_src   = bus.cmd[2] ? result_q : bus.a;
`else
  assign slt_cmd = (bus.cmd == 3'b011);
  assign a_src   = bus.a;
`endif

  assign accept = bus.start && bus.ready;
  assign last   = (cnt_q == CW'(N - 1));

  // One digit of the adder: low DIGIT bits of the shifting operands plus carry
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic [DIGIT:0]   s_ext;
  logic             cout, cin_msb, ovf, slt_bit;

  assign a_dig   = a_q[DIGIT-1:0];
  assign b_dig   = b_q[DIGIT-1:0];
  assign s_ext   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  assign s_dig   = s_ext[DIGIT-1:0];
  assign cout    = s_ext[DIGIT];
  // Carry into the top bit of this digit, recovered from the sum bit itself.
  assign cin_msb = s_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
  assign ovf     = cin_msb ^ cout;
  assign slt_bit = s_dig[DIGIT-1] ^ ovf;
  // Completed digits enter at the top and move down, so after N digits the
  // working register holds the full sum in place.
  assign sum_d   = (sum_q >> DIGIT) | (WIDTH'(s_dig) << SH);
  assign nz_d    = nz_q | (|s_dig);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d
    // unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    state_d = bus.start ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.ready = (state_q != BUSY);
    bus.done  = (state_q == DONE);
  end

  // Operand capture and digit shifting
  always_ff @(posedge clk) begin
    // NOTE: these are pure datapath registers, always loaded on accept before
    // they are read, so they carry no reset.
    if (accept) begin
      a_q   <= a_src;
      b_q   <= bus.b ^ {WIDTH{sub_cmd}};
      sum_q <= '0;
    end else if (state_q == BUSY) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      sum_q <= sum_d;
    end
  end

  // Carry, digit counter and zero accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      cnt_q   <= '0;
      nz_q    <= 1'b0;
      slt_q   <= 1'b0;
    end else if (accept) begin
      carry_q <= sub_cmd;
      cnt_q   <= '0;
      nz_q    <= 1'b0;
      slt_q   <= slt_cmd;
    end else if (state_q == BUSY) begin
      carry_q <= cout;
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
      nz_q    <= nz_d;
    end
  end

  // Result and flags, updated only on the edge that finishes the last digit
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (state_q == BUSY && last) begin
      if (slt_q) begin
        result_q   <= WIDTH'(slt_bit);
        carryout_q <= 1'b0;
        overflow_q <= 1'b0;
        zero_q     <= ~slt_bit;
      end else begin
        result_q   <= sum_d;
        carryout_q <= cout;
        overflow_q <= ovf;
        zero_q     <= ~nz_d;
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.carryout = carryout_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

endmodule
